// File: rtl/time_sender_pkg.sv
// Shared types and constants for the time-to-ASCII frame sender.
package time_sender_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam int         FRAME_LEN   = 10;

endpackage

// File: rtl/time_ascii_sender_bin2ascii.sv
// Combinational 6-bit binary to two ASCII decimal digits (tens saturate at '9').
module bin2ascii_2dig
  import time_sender_pkg::*;
(
  input  logic [5:0] bin_i,
  output logic [7:0] tens_o,
  output logic [7:0] units_o
);

  logic [5:0] tens;
  logic [5:0] units;

  always_comb begin
    tens = bin_i / 6'd10;
    if (tens > 6'd9) tens = 6'd9;
    units = bin_i % 6'd10;
  end

  assign tens_o  = ASCII_ZERO + {2'b00, tens};
  assign units_o = ASCII_ZERO + {2'b00, units};

endmodule

// File: rtl/time_ascii_sender.sv
// Snapshots hour/min/sec on request and streams "HH:MM:SS\r\n" into a UART TX.
// Optional TIME_SENDER_AUTO_SEC_EN: every change of i_sec also raises a request.
//
// TX handshake: o_tx_start is a one-cycle pulse issued only while i_tx_busy is
// low; o_tx_data is held from that pulse until the matching i_tx_done pulse,
// and no further start is issued before that i_tx_done.
module time_ascii_sender #(
  parameter int FRAME_LEN = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_send_req,
  input  logic       i_tx_busy,
  input  logic       i_tx_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_busy
);
  import time_sender_pkg::*;

  state_e     state_q;
  logic [3:0] idx_q;
  logic       pending_q;
  logic [4:0] hour_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  logic       busy_q;

  logic       req;
  logic       last_byte;
  logic [7:0] h10, h1, m10, m1, s10, s1;
  logic [7:0] cur_byte;

`ifdef TIME_SENDER_AUTO_SEC_EN
  logic [5:0] sec_prev_q;
  logic       sec_seen_q;

  // sec_seen_q keeps the first sample after reset from looking like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_prev_q <= 6'd0;
      sec_seen_q <= 1'b0;
    end else begin
      sec_prev_q <= i_sec;
      sec_seen_q <= 1'b1;
    end
  end

  assign req = i_send_req | (sec_seen_q & (i_sec != sec_prev_q));
`else
  assign req = i_send_req;
`endif

  bin2ascii_2dig u_hour (.bin_i({1'b0, hour_q}), .tens_o(h10), .units_o(h1));
  bin2ascii_2dig u_min  (.bin_i(min_q),          .tens_o(m10), .units_o(m1));
  bin2ascii_2dig u_sec  (.bin_i(sec_q),          .tens_o(s10), .units_o(s1));

  assign last_byte = (idx_q == 4'(FRAME_LEN - 1));

  always_comb begin
    cur_byte = ASCII_LF;
    case (idx_q)
      4'd0:    cur_byte = h10;
      4'd1:    cur_byte = h1;
      4'd2:    cur_byte = ASCII_COLON;
      4'd3:    cur_byte = m10;
      4'd4:    cur_byte = m1;
      4'd5:    cur_byte = ASCII_COLON;
      4'd6:    cur_byte = s10;
      4'd7:    cur_byte = s1;
      4'd8:    cur_byte = ASCII_CR;
      default: cur_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      pending_q  <= 1'b0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req || pending_q) begin
            hour_q    <= i_hour;
            min_q     <= i_min;
            sec_q     <= i_sec;
            idx_q     <= 4'd0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          if (req) pending_q <= 1'b1;
          if (!i_tx_busy) begin
            tx_data_q  <= cur_byte;
            tx_start_q <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (req) pending_q <= 1'b1;
          if (i_tx_done) begin
            if (last_byte) begin
              // A pending request keeps o_busy high through the IDLE hop.
              idx_q   <= 4'd0;
              busy_q  <= pending_q | req;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;

endmodule
